arcade_input_mapper: RTL and testbench
======================================

ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of player channels, legal range 1..4.
REQ-002 SHALL have parameter COIN_PULSE, default 16, coin output pulse length in clk_sys cycles, legal range 1..65535.
REQ-003 SHALL have port clk_sys, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port ps2_key, input, 65 bits: [64] is the event toggle, [15:8]=F0 means release, E0 in [15:8] or [23:16] means extended, and [7:0] is the scan code.
REQ-006 SHALL have port joystick, input, PLAYERS*16 bits: slice p holds player p, with bit0 right, bit1 left, bit2 down, bit3 up, bit4 coin, bit5 start1, bit6 start2.
REQ-007 SHALL have port rotate, input, 2 bits: 0 none, 1 90 deg, 2 180 deg, 3 270 deg.
REQ-008 SHALL have port socd_en, input, 1 bit, enabling opposite-direction cancel.
REQ-009 SHALL have port dir, output, PLAYERS*4 bits, active high: slice p is {down,right,left,up} for player p.
REQ-010 SHALL have port start, output, PLAYERS bits, active high start buttons.
REQ-011 SHALL have port coin, output, 1 bit, active-high stretched coin pulse.

Function
REQ-012 SHALL detect a keyboard event when ps2_key[64] differs from its registered copy; pressed = ([15:8] != F0).
REQ-013 SHALL ignore an event (no key state change) when ps2_key[63:24] is nonzero.
REQ-014 SHALL apply these key maps: arrows 75/72/6B/74 (extended flag don't-care) to player 0 up/down/left/right; W/S/A/D (1D/1B/1C/23, non-extended) to player 1 up/down/left/right, only when PLAYERS>=2; F1 (05) to start[0]; F2 (06) to start[1], or to start[0] when PLAYERS=1; F3 (04) to coin request.
REQ-015 SHALL update the key state register one cycle after the toggle edge, setting the bit to pressed.
REQ-016 SHALL form raw direction for each player as joystick bits OR mapped key bits.
REQ-017 SHALL rotate raw direction to output as follows: rot1: up<-left, down<-right, left<-down, right<-up; rot2: up<-down, down<-up, left<-right, right<-left; rot3: up<-right, down<-left, left<-up, right<-down.
REQ-018 SHALL, when socd_en=1, clear both bits after rotation when up&down or left&right are both set.
REQ-019 SHALL register dir and start, giving 1 cycle latency from joystick/rotate/socd_en and 2 cycles from ps2 toggle.
REQ-020 SHALL set start[0] = F1 OR joystick bit5 of any player, and start[1] = F2 OR joystick bit6 of any player.
REQ-021 SHALL form coin request = F3 key OR bit4 of any player.
REQ-022 SHALL implement a coin FSM: IDLE -> PULSE on request rising edge, asserting coin for exactly COIN_PULSE cycles starting the cycle after the edge.
REQ-023 SHALL move PULSE -> WAIT when the counter expires, remaining in WAIT until the request is 0, then returning to IDLE.
REQ-024 SHALL ignore new request edges in PULSE or WAIT, so there is no retrigger or extension.
REQ-025 SHALL keep the coin counter at least 16 bits wide, saturating-safe with no wrap to a second pulse.
REQ-026 SHALL take a rotate change mid-press effect on the next registered output with no glitch cycle.

Reset
REQ-027 SHALL, while RESET=1, drive dir=0, start=0, coin=0, clear all key states and the FSM to IDLE, and set a prime flag.
REQ-028 SHALL, in the first cycle after RESET release, load the toggle copy from ps2_key[64] with no event recognised, then clear prime.
REQ-029 SHALL, on RESET during PULSE, end the coin pulse immediately; after release, a held request SHALL NOT produce a pulse until it is released and re-pressed (the request-edge register resets to 1).

Verification
REQ-030 SHALL verify: PLAYERS=2, rotate=0, joystick p0 bit3=1 -> dir[0]=1 one cycle later; with rotate=1, dir[3:0]=4'b0100 (right).
REQ-031 SHALL verify: ps2_key toggle with code E0_75 pressed -> dir[0]=1 two cycles later; toggle with F0 release -> 0; toggle with [63:24]!=0 -> unchanged.
REQ-032 SHALL verify: COIN_PULSE=16, F3 held 100 cycles -> coin high exactly 16 cycles, once; release then press -> second 16-cycle pulse.
REQ-033 SHALL verify: socd_en=1, joystick left+right and keyboard up -> dir p0 = 4'b0001; socd_en=0 -> 4'b0111.
REQ-034 SHALL verify: ps2_key[64]=1 held through RESET release -> no key state change; coin pulse in progress at cycle 5 plus RESET -> coin=0 immediately, and no new pulse while the request stays held.
REQ-035 SHALL verify: PLAYERS=1, F2 press -> start[0]=1; W key press -> no output change.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// Arcade control mapper: merges PS/2 keys and joystick words into rotated, SOCD-filtered
// per-player directions, start buttons and a fixed-length coin pulse.
module arcade_input_mapper #(
  parameter int PLAYERS    = 2,
  parameter int COIN_PULSE = 16
) (
  input  logic                   clk_sys,
  input  logic                   RESET,
  input  logic [64:0]            ps2_key,
  input  logic [PLAYERS*16-1:0]  joystick,
  input  logic [1:0]             rotate,
  input  logic                   socd_en,
  output logic [PLAYERS*4-1:0]   dir,
  output logic [PLAYERS-1:0]     start,
  output logic                   coin
);

  typedef struct packed {
    logic p0_up, p0_down, p0_left, p0_right;
    logic p1_up, p1_down, p1_left, p1_right;
    logic f1, f2, f3;
  } key_state_t;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} coin_state_t;

  key_state_t          r_keys;
  logic                r_toggle;
  logic                r_prime;
  logic [PLAYERS*4-1:0] r_dir;
  logic [PLAYERS-1:0]  r_start;
  coin_state_t         r_state;
  coin_state_t         w_state_next;
  logic [15:0]         r_cnt;
  logic                r_req_d;

  logic                w_event;
  logic                w_pressed;
  logic                w_ext;
  logic [3:0]          w_raw;
  logic [PLAYERS*4-1:0] w_dir_next;
  logic [PLAYERS-1:0]  w_start_next;
  logic                w_req;
  logic                w_any_s1;
  logic                w_any_s2;
  logic                w_unused;

  assign w_unused  = ^joystick;
  assign w_pressed = (ps2_key[15:8] != 8'hF0);
  assign w_ext     = (ps2_key[15:8] == 8'hE0) || (ps2_key[23:16] == 8'hE0);
  // The first cycle after reset only samples the toggle, so a level already high is not an event.
  assign w_event   = !r_prime && (ps2_key[64] != r_toggle) && (ps2_key[63:24] == 40'd0);

  // Raw and result both ordered {down,right,left,up}.
  function automatic logic [3:0] map_dir(input logic [3:0] raw, input logic [1:0] rot,
                                         input logic socd);
    logic u, d, l, r;
    case (rot)
      2'd1:    begin u = raw[1]; d = raw[2]; l = raw[3]; r = raw[0]; end
      2'd2:    begin u = raw[3]; d = raw[0]; l = raw[2]; r = raw[1]; end
      2'd3:    begin u = raw[2]; d = raw[1]; l = raw[0]; r = raw[3]; end
      default: begin u = raw[0]; d = raw[3]; l = raw[1]; r = raw[2]; end
    endcase
    if (socd && u && d) begin u = 1'b0; d = 1'b0; end
    if (socd && l && r) begin l = 1'b0; r = 1'b0; end
    return {d, r, l, u};
  endfunction

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_keys   <= '0;
      r_toggle <= 1'b0;
      r_prime  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_toggle <= ps2_key[64];
      r_prime  <= 1'b0;
      if (w_event) begin
        case (ps2_key[7:0])
          8'h75:   r_keys.p0_up    <= w_pressed;
          8'h72:   r_keys.p0_down  <= w_pressed;
          8'h6B:   r_keys.p0_left  <= w_pressed;
          8'h74:   r_keys.p0_right <= w_pressed;
          8'h1D:   if (!w_ext) r_keys.p1_up    <= w_pressed;
          8'h1B:   if (!w_ext) r_keys.p1_down  <= w_pressed;
          8'h1C:   if (!w_ext) r_keys.p1_left  <= w_pressed;
          8'h23:   if (!w_ext) r_keys.p1_right <= w_pressed;
          8'h05:   r_keys.f1 <= w_pressed;
          8'h06:   r_keys.f2 <= w_pressed;
          8'h04:   r_keys.f3 <= w_pressed;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_dir_next = '0;
    w_raw      = '0;
    w_req      = r_keys.f3;
    w_any_s1   = 1'b0;
    w_any_s2   = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_raw = {joystick[p*16+2], joystick[p*16+0], joystick[p*16+1], joystick[p*16+3]};
      if (p == 0) w_raw |= {r_keys.p0_down, r_keys.p0_right, r_keys.p0_left, r_keys.p0_up};
      if (p == 1) w_raw |= {r_keys.p1_down, r_keys.p1_right, r_keys.p1_left, r_keys.p1_up};
      w_dir_next[p*4 +: 4] = map_dir(w_raw, rotate, socd_en);
      w_req    |= joystick[p*16+4];
      w_any_s1 |= joystick[p*16+5];
      w_any_s2 |= joystick[p*16+6];
    end
  end

  if (PLAYERS == 1) begin : g_start_single
    assign w_start_next = r_keys.f1 | r_keys.f2 | w_any_s1 | w_any_s2;
  end else begin : g_start_multi
    always_comb begin
      w_start_next    = '0;
      w_start_next[0] = r_keys.f1 | w_any_s1;
      w_start_next[1] = r_keys.f2 | w_any_s2;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_dir   <= '0;
      r_start <= '0;
    end else begin
      r_dir   <= w_dir_next;
      r_start <= w_start_next;
    end
  end

  assign dir   = r_dir;
  assign start = r_start;

  // Coin FSM: state register.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req_d <= 1'b1;  // a request held across reset must be released before it can fire
    end else begin
      r_state <= w_state_next;
      r_req_d <= w_req;
      if (r_state == S_IDLE && w_state_next == S_PULSE)
        r_cnt <= 16'(COIN_PULSE - 1);
      else if (r_state == S_PULSE && r_cnt != 16'd0)
        r_cnt <= r_cnt - 16'd1;
    end
  end

  // Coin FSM: next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req && !r_req_d) w_state_next = S_PULSE;
      S_PULSE: if (r_cnt == 16'd0)    w_state_next = S_WAIT;
      S_WAIT:  if (!w_req)            w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Coin FSM: outputs.
  always_comb begin
    coin = (r_state == S_PULSE);
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: a 2-player instance for most features and a
// 1-player instance for the single-player key remapping.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic [64:0] ps2_key;
  logic [31:0] joystick;
  logic [1:0]  rotate;
  logic        socd_en;
  logic [7:0]  dir;
  logic [1:0]  start;
  logic        coin;

  logic [64:0] ps2_key_b;
  logic [15:0] joystick_b;
  logic [3:0]  dir_b;
  logic [0:0]  start_b;
  logic        coin_b;

  logic        tog   = 1'b0;
  logic        tog_b = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(.PLAYERS(2), .COIN_PULSE(16)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joystick(joystick),
    .rotate(rotate), .socd_en(socd_en), .dir(dir), .start(start), .coin(coin)
  );

  arcade_input_mapper #(.PLAYERS(1), .COIN_PULSE(16)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key_b), .joystick(joystick_b),
    .rotate(2'd0), .socd_en(1'b0), .dir(dir_b), .start(start_b), .coin(coin_b)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One keyboard event on the 2-player instance: flips the toggle and presents the bytes.
  task automatic send_key(input logic [7:0] code, input bit ext, input bit rel,
                          input logic [39:0] junk);
    logic [7:0] b1, b2;
    b2  = (ext && rel) ? 8'hE0 : 8'h00;
    b1  = rel ? 8'hF0 : (ext ? 8'hE0 : 8'h00);
    tog = ~tog;
    ps2_key = {tog, junk, b2, b1, code};
  endtask

  task automatic test_reset;
    RESET = 1'b1; joystick = 32'h0000_0008; rotate = 2'd0; socd_en = 1'b0;
    ps2_key = '0; ps2_key_b = '0; joystick_b = '0;
    step(3);
    checks++; if (dir !== 8'h00)  begin failures++; $display("FAIL reset_dir: got %h want 00", dir); end
    checks++; if (start !== 2'b00) begin failures++; $display("FAIL reset_start: got %b want 00", start); end
    checks++; if (coin !== 1'b0)  begin failures++; $display("FAIL reset_coin: got %b want 0", coin); end
    joystick = '0;
    step(1);
    RESET = 1'b0;
    step(2);
  endtask

  task automatic test_joystick_rotate;
    joystick = 32'h0000_0008;  // p0 up
    #1;
    checks++; if (dir !== 8'h00) begin failures++; $display("FAIL joy_latency: got %h want 00", dir); end
    step(1);
    checks++; if (dir !== 8'h01) begin failures++; $display("FAIL joy_up_rot0: got %h want 01", dir); end
    rotate = 2'd1; step(1);
    checks++; if (dir !== 8'h04) begin failures++; $display("FAIL joy_up_rot1: got %h want 04", dir); end
    rotate = 2'd2; step(1);
    checks++; if (dir !== 8'h08) begin failures++; $display("FAIL joy_up_rot2: got %h want 08", dir); end
    rotate = 2'd3; step(1);
    checks++; if (dir !== 8'h02) begin failures++; $display("FAIL joy_up_rot3: got %h want 02", dir); end
    rotate = 2'd0; joystick = 32'h0001_0000;  // p1 right
    step(1);
    checks++; if (dir !== 8'h40) begin failures++; $display("FAIL joy_p1_right: got %h want 40", dir); end
    joystick = '0; step(1);
  endtask

  task automatic test_ps2_keys;
    send_key(8'h75, 1'b1, 1'b0, 40'd0);
    step(1);
    checks++; if (dir !== 8'h00) begin failures++; $display("FAIL key_latency: got %h want 00", dir); end
    step(1);
    checks++; if (dir !== 8'h01) begin failures++; $display("FAIL key_e075_press: got %h want 01", dir); end
    send_key(8'h75, 1'b1, 1'b1, 40'd0); step(2);
    checks++; if (dir !== 8'h00) begin failures++; $display("FAIL key_e075_release: got %h want 00", dir); end
    send_key(8'h75, 1'b1, 1'b0, 40'h00_0000_0100); step(2);
    checks++; if (dir !== 8'h00) begin failures++; $display("FAIL key_junk_ignored: got %h want 00", dir); end
    send_key(8'h1D, 1'b0, 1'b0, 40'd0); step(2);
    checks++; if (dir !== 8'h10) begin failures++; $display("FAIL key_w_press: got %h want 10", dir); end
    send_key(8'h1D, 1'b1, 1'b1, 40'd0); step(2);
    checks++; if (dir !== 8'h10) begin failures++; $display("FAIL key_w_ext_ignored: got %h want 10", dir); end
    send_key(8'h1D, 1'b0, 1'b1, 40'd0); step(2);
    checks++; if (dir !== 8'h00) begin failures++; $display("FAIL key_w_release: got %h want 00", dir); end
  endtask

  task automatic test_socd;
    joystick = 32'h0000_0003;  // p0 right + left
    socd_en  = 1'b1;
    send_key(8'h75, 1'b1, 1'b0, 40'd0); step(2);
    checks++; if (dir[3:0] !== 4'b0001) begin failures++; $display("FAIL socd_lr_on: got %b want 0001", dir[3:0]); end
    socd_en = 1'b0; step(1);
    checks++; if (dir[3:0] !== 4'b0111) begin failures++; $display("FAIL socd_lr_off: got %b want 0111", dir[3:0]); end
    send_key(8'h75, 1'b1, 1'b1, 40'd0);
    joystick = 32'h0000_000C;  // p0 up + down
    socd_en  = 1'b1; step(2);
    checks++; if (dir[3:0] !== 4'b0000) begin failures++; $display("FAIL socd_ud_on: got %b want 0000", dir[3:0]); end
    socd_en = 1'b0; step(1);
    checks++; if (dir[3:0] !== 4'b1001) begin failures++; $display("FAIL socd_ud_off: got %b want 1001", dir[3:0]); end
    joystick = '0; step(1);
  endtask

  task automatic test_start;
    send_key(8'h05, 1'b0, 1'b0, 40'd0); step(2);
    checks++; if (start !== 2'b01) begin failures++; $display("FAIL start_f1: got %b want 01", start); end
    send_key(8'h06, 1'b0, 1'b0, 40'd0); step(2);
    checks++; if (start !== 2'b11) begin failures++; $display("FAIL start_f1f2: got %b want 11", start); end
    send_key(8'h05, 1'b0, 1'b1, 40'd0); step(1);
    send_key(8'h06, 1'b0, 1'b1, 40'd0); step(2);
    checks++; if (start !== 2'b00) begin failures++; $display("FAIL start_release: got %b want 00", start); end
    joystick = 32'h0020_0000;  // p1 start1
    step(1);
    checks++; if (start !== 2'b01) begin failures++; $display("FAIL start_joy_p1: got %b want 01", start); end
    joystick = 32'h0000_0040;  // p0 start2
    step(1);
    checks++; if (start !== 2'b10) begin failures++; $display("FAIL start_joy_p0_s2: got %b want 10", start); end
    joystick = '0; step(1);
  endtask

  task automatic test_coin;
    int cnt, rises, first;
    logic prev;
    cnt = 0; rises = 0; first = 0; prev = 1'b0;
    send_key(8'h04, 1'b0, 1'b0, 40'd0);
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (coin) begin cnt++; if (first == 0) first = k; end
      if (coin && !prev) rises++;
      prev = coin;
    end
    checks++; if (cnt !== 16)  begin failures++; $display("FAIL coin_len: got %0d want 16", cnt); end
    checks++; if (rises !== 1) begin failures++; $display("FAIL coin_once: got %0d pulses want 1", rises); end
    checks++; if (first !== 2) begin failures++; $display("FAIL coin_start: got cycle %0d want 2", first); end
    send_key(8'h04, 1'b0, 1'b1, 40'd0); step(4);
    cnt = 0; rises = 0; prev = 1'b0;
    send_key(8'h04, 1'b0, 1'b0, 40'd0);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (coin) cnt++;
      if (coin && !prev) rises++;
      prev = coin;
    end
    checks++; if (cnt !== 16 || rises !== 1) begin
      failures++; $display("FAIL coin_second: got %0d cycles/%0d pulses want 16/1", cnt, rises);
    end
    send_key(8'h04, 1'b0, 1'b1, 40'd0); step(4);
  endtask

  task automatic test_reset_mid_pulse;
    int cnt;
    joystick = 32'h0000_0010;  // p0 coin held
    step(5);
    checks++; if (coin !== 1'b1) begin failures++; $display("FAIL coin_mid_pulse: got %b want 1", coin); end
    RESET = 1'b1; #1;
    checks++; if (coin !== 1'b0) begin failures++; $display("FAIL coin_reset_abort: got %b want 0", coin); end
    step(2);
    RESET = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(1); if (coin) cnt++; end
    checks++; if (cnt !== 0) begin failures++; $display("FAIL coin_held_after_reset: got %0d high cycles want 0", cnt); end
    joystick = '0; step(3);
    joystick = 32'h0000_0010;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin step(1); if (coin) cnt++; end
    checks++; if (cnt !== 16) begin failures++; $display("FAIL coin_repress: got %0d want 16", cnt); end
    joystick = '0; step(3);
  endtask

  task automatic test_toggle_through_reset;
    RESET = 1'b1; step(1);
    tog = 1'b0;
    send_key(8'h75, 1'b1, 1'b0, 40'd0);  // toggle now 1, held across release
    step(2);
    RESET = 1'b0;
    step(3);
    checks++; if (dir !== 8'h00) begin failures++; $display("FAIL prime_no_event: got %h want 00", dir); end
    send_key(8'h75, 1'b1, 1'b0, 40'd0); step(2);
    checks++; if (dir !== 8'h01) begin failures++; $display("FAIL post_reset_press: got %h want 01", dir); end
    send_key(8'h75, 1'b1, 1'b1, 40'd0); step(2);
  endtask

  task automatic test_single_player;
    tog_b = ~tog_b; ps2_key_b = {tog_b, 40'd0, 8'h00, 8'h00, 8'h06}; step(2);
    checks++; if (start_b !== 1'b1) begin failures++; $display("FAIL p1cfg_f2_start0: got %b want 1", start_b); end
    tog_b = ~tog_b; ps2_key_b = {tog_b, 40'd0, 8'h00, 8'h00, 8'h1D}; step(2);
    checks++; if (dir_b !== 4'h0) begin failures++; $display("FAIL p1cfg_w_ignored: got %h want 0", dir_b); end
    joystick_b = 16'h0008; step(1);
    checks++; if (dir_b !== 4'h1) begin failures++; $display("FAIL p1cfg_joy_up: got %h want 1", dir_b); end
    joystick_b = '0;
    tog_b = ~tog_b; ps2_key_b = {tog_b, 40'd0, 8'h00, 8'hF0, 8'h06}; step(2);
    checks++; if (start_b !== 1'b0) begin failures++; $display("FAIL p1cfg_f2_release: got %b want 0", start_b); end
  endtask

  initial begin
    test_reset();
    test_joystick_rotate();
    test_ps2_keys();
    test_socd();
    test_start();
    test_coin();
    test_reset_mid_pulse();
    test_toggle_through_reset();
    test_single_player();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
